fifo_replay: RTL
================

Name: fifo_replay

Overview:
- Show-ahead (first-word-fall-through) synchronous FIFO whose DEPTH may be any integer ≥2, not only a power of two. All pointers wrap explicitly.
- Adds a circular replay mode: reads walk the stored contents repeatedly without consuming them.
- Adds overflow/underflow pulses, a flush input and a registered fill level.
- Drop-in successor to the existing fifo for stream buffers and pattern/sequence replay in the datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 24, number of entries; any value ≥2.
- ALMOST_FULL_FREE, 1, almost_full asserts when free entries ≤ this value.
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserts when fill ≤ this value.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of pointers/fill; memory contents untouched.
- circular  in  1  replay mode enable.
- datain  in  WIDTH  write data.
- write  in  1  write request.
- read  in  1  read/advance request.
- dataout  out  WIDTH  word at current read position; meaningful only when valid=1.
- valid  out  1  dataout holds a stored word (fill≠0).
- empty  out  1  fill==0.
- almost_empty  out  1  fill ≤ ALMOST_EMPTY_LEVEL.
- full  out  1  fill==DEPTH.
- almost_full  out  1  fill ≥ DEPTH−ALMOST_FULL_FREE.
- fill_level  out  $clog2(DEPTH+1)  entries stored.
- wrap  out  1  one-cycle pulse: replay pointer returned to head.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read with valid=0.

Behaviour:
- **Reset / flush:** reset has priority; flush has identical effect on state.
  - head, tail, replay = 0; fill = 0; valid = 0; empty = 1; full = 0.
  - almost_empty = 1; almost_full = (DEPTH ≤ ALMOST_FULL_FREE).
  - wrap, overflow, underflow = 0.
  - Writes and reads in the same cycle as reset/flush are ignored and raise no pulses.
- **Pointer arithmetic:** head, tail, replay are $clog2(DEPTH) bits. Increment = (p==DEPTH−1) ? 0 : p+1. No reliance on power-of-two rollover.
- **Memory and dataout:**
  - Memory is written at tail on an accepted write.
  - dataout = mem[circular ? replay : head]; this is an asynchronous read of registered state.
- **Write acceptance:** write && (fill≠DEPTH || (read && valid && !circular)).
  - Full with a simultaneous non-circular pop: the write is accepted and fill is unchanged.
  - Otherwise a write while full is dropped and overflow pulses on the next cycle.
- **Write latency:** a word written in cycle N is visible on dataout with valid=1 in cycle N+1 if the FIFO was empty.
- **Read in non-circular mode (circular=0):**
  - read && valid pops: head increments, fill decrements (unless a write is also accepted).
  - read && !valid: ignored, underflow pulses; any accompanying write is still accepted.
  - replay is loaded with head every cycle circular=0 (the next-cycle head when a pop occurs).
- **Read in circular mode (circular=1):**
  - read && valid advances replay; head and fill are unchanged.
  - If inc(replay) == tail_reg (value before this cycle's write), replay is loaded with head instead and wrap pulses the next cycle.
  - Full case (tail==head): exactly DEPTH reads per loop.
  - Writes in circular mode append normally. A word written in the cycle replay wraps joins from the next loop.
  - read && !valid raises underflow.
- **Mode changes:** circular 1→0 takes effect in the same cycle; dataout returns to mem[head] and replay reloads. Switching 0→1 starts replay at head.
- **Status outputs:** all are registered from next-state fill, so they agree with fill_level in the same cycle. overflow and underflow may both pulse in one cycle.

Test Plan:
- **Non-power-of-two fill:** DEPTH=5; write 0xA1..0xA5 on consecutive cycles.
  - Expect fill_level 1..5, full=1 after the 5th write; almost_full=1 at fill 4.
  - 6th write 0xA6 → overflow pulse, fill stays 5.
  - Then 5 reads return 0xA1..0xA5, empty=1 after the last.
- **Pointer wrap:** DEPTH=5; perform 13 alternating write/read pairs with data = index.
  - dataout matches index every read, fill ≤1, no overflow/underflow.
  - Pointers pass the 4→0 wrap twice.
- **Full with simultaneous read+write:** with fill=5, read+write 0xB0.
  - Write accepted, fill stays 5, no overflow.
  - 0xB0 emerges as the 5th subsequent read.
- **Circular replay:** load 0x10, 0x20, 0x30; circular=1; read 7 times.
  - dataout sequence 10,20,30,10,20,30,10.
  - wrap pulses after the 3rd and 6th reads; fill_level stays 3.
  - circular=0, then one read returns 0x10 and fill becomes 2.
- **Empty corner cases:**
  - Empty with read+write 0xC1 → underflow pulse, write accepted; next cycle valid=1, dataout=0xC1.
  - Empty with read only → underflow, fill stays 0.
- **Reset/flush mid-operation:** fill=3, in circular mode, pulse flush together with write.
  - Next cycle fill_level=0, empty=1, valid=0, no overflow/underflow/wrap.
  - Repeat with reset → same values.

Source files
------------

// File: rtl/fifo_replay.sv
// fifo_replay: show-ahead synchronous FIFO for any DEPTH >= 2, with a circular
// replay mode that walks the stored words repeatedly without consuming them.
// Status flags are registered from the next-state fill so they always agree
// with fill_level. Error pulses (overflow/underflow/wrap) last one cycle.
module fifo_replay #(
    parameter int WIDTH              = 32,
    parameter int DEPTH              = 24,
    parameter int ALMOST_FULL_FREE   = 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       circular,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       write,
    input  logic                       read,
    output logic [WIDTH-1:0]           dataout,
    output logic                       valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       wrap,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    // Explicit wrap so non-power-of-two depths never rely on natural rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head, r_tail, r_replay;
    logic [FW-1:0]    r_fill;
    logic             r_valid, r_empty, r_almost_empty, r_full, r_almost_full;
    logic             r_wrap, r_overflow, r_underflow;

    logic             w_clear, w_pop, w_adv, w_wr_acc;
    logic [PW-1:0]    w_head_nxt, w_tail_nxt, w_replay_nxt, w_rd_ptr;
    logic [FW-1:0]    w_fill_nxt;
    logic             w_wrap_nxt;

    assign w_clear  = reset || flush;
    assign w_pop    = read && r_valid && !circular;
    assign w_adv    = read && r_valid && circular;
    // A full FIFO still takes a write when a pop frees a slot in the same cycle.
    assign w_wr_acc = write && ((r_fill != FILL_MAX) || w_pop);

    assign w_head_nxt = w_pop    ? ptr_inc(r_head) : r_head;
    assign w_tail_nxt = w_wr_acc ? ptr_inc(r_tail) : r_tail;

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_fill_nxt = r_fill;
        if (w_wr_acc && !w_pop)
            w_fill_nxt = r_fill + 1'b1;
        else if (!w_wr_acc && w_pop)
            w_fill_nxt = r_fill - 1'b1;
    end

    // Replay pointer: tracks head outside replay mode, loops back at the pre-write tail.
    always_comb begin
        w_replay_nxt = r_replay;
        w_wrap_nxt   = 1'b0;
        if (!circular) begin
            w_replay_nxt = w_head_nxt;
        end else if (w_adv) begin
            if (ptr_inc(r_replay) == r_tail) begin
                w_replay_nxt = r_head;
                w_wrap_nxt   = 1'b1;
            end else begin
                w_replay_nxt = ptr_inc(r_replay);
            end
        end
    end

    // Storage array; writes during reset/flush are discarded.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset; valid/fill guard its contents.
        if (!w_clear && w_wr_acc)
            r_mem[r_tail] <= datain;
    end

    // Pointer, fill, status and pulse registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (w_clear) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_replay       <= '0;
            r_fill         <= '0;
            r_valid        <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= (DEPTH <= ALMOST_FULL_FREE);
            r_wrap         <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_head         <= w_head_nxt;
            r_tail         <= w_tail_nxt;
            r_replay       <= w_replay_nxt;
            r_fill         <= w_fill_nxt;
            r_valid        <= (w_fill_nxt != '0);
            r_empty        <= (w_fill_nxt == '0);
            r_almost_empty <= (int'(w_fill_nxt) <= ALMOST_EMPTY_LEVEL);
            r_full         <= (w_fill_nxt == FILL_MAX);
            r_almost_full  <= ((int'(w_fill_nxt) + ALMOST_FULL_FREE) >= DEPTH);
            r_wrap         <= w_wrap_nxt;
            r_overflow     <= write && !w_wr_acc;
            r_underflow    <= read && !r_valid;
        end
    end

    assign w_rd_ptr     = circular ? r_replay : r_head;
    assign dataout      = r_mem[w_rd_ptr];
    assign valid        = r_valid;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign fill_level   = r_fill;
    assign wrap         = r_wrap;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
